// File: rtl/conv_encoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vit_pkg
// Description : Shared types, generator constants and helpers for the
//               Viterbi/PRML transmit-side convolutional encoder.
// Revision    : 1.0 - initial release
// ============================================================================
package vit_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SERIAL = 2'd1,
        TAIL   = 2'd2
    } enc_state_t;

    // Polynomial i lives at bits [i*K +: K]; bit 0 taps the newest stage.
    localparam logic [5:0]  G_K3_DEFAULT = 6'b111_011;
    localparam logic [13:0] G_K7_NASA    = {7'o133, 7'o171};

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/conv_codeword.sv
`default_nettype none
// ============================================================================
// Module      : conv_codeword
// Description : Combinational map from the updated shift register to the
//               N coded bits of a rate-1/N convolutional code.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_codeword
    import vit_pkg::*;
#(
    parameter int             K = 3,
    parameter int             N = 2,
    parameter logic [N*K-1:0] G = G_K3_DEFAULT
) (
    input  logic [K-1:0] s,
    output logic [N-1:0] c
);

    genvar i;
    generate
        for (i = 0; i < N; i++) begin : g_poly
            assign c[i] = ^(G[i*K +: K] & s);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/conv_encoder.sv
`default_nettype none
// ============================================================================
// Module      : conv_encoder
// Description : Rate-1/N feed-forward convolutional encoder with serial coded
//               output and optional K-1 zero-bit trellis termination.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_encoder
    import vit_pkg::*;
#(
    parameter int             K = 3,
    parameter int             N = 2,
    parameter logic [N*K-1:0] G = G_K3_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic in_valid,
    output logic in_ready,
    input  logic in_data,
    input  logic in_last,
    output logic out_valid,
    input  logic out_ready,
    output logic out_data,
    output logic out_last
);

    localparam int IW = clog2(N);
    localparam int TW = clog2(K);

    localparam logic [1:0]    c_ST_IDLE   = IDLE;
    localparam logic [1:0]    c_ST_SERIAL = SERIAL;
    localparam logic [1:0]    c_ST_TAIL   = TAIL;
    localparam logic [IW-1:0] c_IDX_LAST  = IW'(N - 1);
    localparam logic [TW-1:0] c_TAIL_LAST = TW'(K - 1);

    logic [1:0]    r_state, w_state_nxt;
    logic [K-1:0]  r_s, w_s_enc;
    logic [N-1:0]  r_c, w_cw, w_c_nxt;
    logic [IW-1:0] r_idx, w_idx_nxt;
    logic [TW-1:0] r_tail_cnt, w_tail_nxt;
    logic          r_tail_pending, w_tail_pending_nxt;
    logic          r_out_valid, r_out_data, r_out_last;
    logic          w_enc, w_enc_bit, w_out_hs, w_at_last, w_accept;

    assign w_s_enc   = {r_s[K-2:0], w_enc_bit};
    assign w_at_last = (r_idx == c_IDX_LAST);
    assign w_out_hs  = (r_state != c_ST_IDLE) && out_ready;
    assign in_ready  = (r_state == c_ST_IDLE) ||
                       ((r_state == c_ST_SERIAL) && w_at_last && out_ready && !r_tail_pending);
    assign w_accept  = in_valid && in_ready;

    conv_codeword #(
        .K (K),
        .N (N),
        .G (G)
    ) u_codeword (
        .s (w_s_enc),
        .c (w_cw)
    );

    always_comb begin
        w_state_nxt        = r_state;
        w_idx_nxt          = r_idx;
        w_tail_nxt         = r_tail_cnt;
        w_tail_pending_nxt = r_tail_pending;
        w_enc              = 1'b0;
        w_enc_bit          = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_accept) begin
                    w_enc              = 1'b1;
                    w_enc_bit          = in_data;
                    w_idx_nxt          = '0;
                    w_tail_pending_nxt = in_last;
                    w_state_nxt        = c_ST_SERIAL;
                end
            end
            c_ST_SERIAL: begin
                if (w_out_hs) begin
                    if (!w_at_last) begin
                        w_idx_nxt = r_idx + 1'b1;
                    end else if (r_tail_pending) begin
                        w_enc       = 1'b1;
                        w_idx_nxt   = '0;
                        w_tail_nxt  = TW'(1);
                        w_state_nxt = c_ST_TAIL;
                    end else if (w_accept) begin
                        // Next info bit rides the final handshake: no bubble.
                        w_enc              = 1'b1;
                        w_enc_bit          = in_data;
                        w_idx_nxt          = '0;
                        w_tail_pending_nxt = in_last;
                    end else begin
                        w_state_nxt = c_ST_IDLE;
                    end
                end
            end
            c_ST_TAIL: begin
                if (w_out_hs) begin
                    if (!w_at_last) begin
                        w_idx_nxt = r_idx + 1'b1;
                    end else if (r_tail_cnt < c_TAIL_LAST) begin
                        w_enc      = 1'b1;
                        w_idx_nxt  = '0;
                        w_tail_nxt = r_tail_cnt + 1'b1;
                    end else begin
                        w_tail_nxt         = '0;
                        w_tail_pending_nxt = 1'b0;
                        w_state_nxt        = c_ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    assign w_c_nxt = w_enc ? w_cw : r_c;

    // Outputs are registered from next-state values so they track the FSM.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state        <= c_ST_IDLE;
            r_s            <= '0;
            r_c            <= '0;
            r_idx          <= '0;
            r_tail_cnt     <= '0;
            r_tail_pending <= 1'b0;
            r_out_valid    <= 1'b0;
            r_out_data     <= 1'b0;
            r_out_last     <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_s            <= w_enc ? w_s_enc : r_s;
            r_c            <= w_c_nxt;
            r_idx          <= w_idx_nxt;
            r_tail_cnt     <= w_tail_nxt;
            r_tail_pending <= w_tail_pending_nxt;
            r_out_valid    <= (w_state_nxt != c_ST_IDLE);
            r_out_data     <= w_c_nxt[w_idx_nxt];
            r_out_last     <= (w_state_nxt == c_ST_TAIL) && (w_tail_nxt == c_TAIL_LAST) &&
                              (w_idx_nxt == c_IDX_LAST);
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;

endmodule
`default_nettype wire

// File: doc/conv_encoder.md
# conv_encoder

Parametrised rate-1/N feed-forward convolutional encoder for the transmit side of the Viterbi/PRML datapath. It accepts one information bit per valid/ready handshake and emits the N coded bits serially, one per clock, on a valid/ready stream. When the block is marked last, it appends K-1 zero tail bits so the downstream Viterbi decoder always sees a trellis terminated in state 0. All logic runs on a single clock; there is no derived clock.

## Interface
Parameters:
- K, default 3: constraint length (shift-register depth, input included); legal range 2..9.
- N, default 2: coded bits per information bit; legal range 2..4.
- G, default 6'b111_011: packed generator polynomials, N*K bits wide.
  - Polynomial i is G[i*K +: K].
  - Bit j of a polynomial taps shift-register stage j; stage 0 is the newest bit.

Ports:
- clock, in, 1: single clock, rising edge.
- reset, in, 1: asynchronous, active-high.
- in_valid, in, 1: an information bit is offered.
- in_ready, out, 1: encoder accepts in_data/in_last this cycle.
- in_data, in, 1: information bit.
- in_last, in, 1: the offered bit ends the block, so a tail follows.
- out_valid, out, 1: out_data holds a coded bit.
- out_ready, in, 1: downstream takes out_data this cycle.
- out_data, out, 1: coded bit.
- out_last, out, 1: marks the final coded bit of the tail.

## Operation
- Shift register s[K-1:0]. On every encoded bit b: s <= {s[K-2:0], b}. Codeword c[i] = ^(G_i & s_new).
- FSM states: IDLE, SERIAL, TAIL.
  - IDLE: in_ready=1, out_valid=0. An accept updates s, latches c, sets idx=0 and moves to SERIAL. If in_last was accepted, tail_pending=1.
  - SERIAL: out_valid=1, out_data=c[idx], so c[0] goes out first. Each out handshake increments idx.
  - On the handshake at idx==N-1:
    - If tail_pending: go to TAIL and load a zero tail bit. That updates s and c, and tail_cnt=1.
    - Else if in_valid: accept the next bit in the same cycle, so the stream runs back-to-back at N clocks per info bit.
    - Else: go to IDLE.
  - in_ready in SERIAL = (idx==N-1) && out_ready && !tail_pending.
  - TAIL: serialises like SERIAL. in_ready=0. On the handshake at idx==N-1:
    - If tail_cnt < K-1: encode another zero and increment tail_cnt.
    - Else: clear tail_pending and go to IDLE. s is now all-zero.
- out_last=1 only while in TAIL with tail_cnt==K-1 and idx==N-1.
- Output stalls (out_valid=1, out_ready=0) hold out_data, idx and s unchanged, with no loss or duplication.
- Without in_last, s carries across blocks; the trellis is unterminated.

## Timing
- Reset (asynchronous, takes effect immediately):
  - state=IDLE; s, c, idx, tail_cnt and tail_pending all 0.
  - out_valid=0, out_data=0, out_last=0.
  - in_ready=1 from the first clock after deassertion.
- Latency: the first coded bit is valid the clock after an accept.
- Throughput: one coded bit per clock when out_ready is held high.
- Reset asserted mid-block drops the partial codeword and any tail. No out_last is produced for that block.
- in_valid during TAIL is ignored; it is not accepted until the tail completes.
- All outputs are registered except in_ready, which is combinational from state, idx, out_ready and tail_pending.

## Structure
- Package vit_pkg holds:
  - the enum enc_state_t {IDLE, SERIAL, TAIL};
  - the default polynomial constants G_K3_DEFAULT=6'b111_011 and G_K7_NASA (octal 171/133);
  - the function clog2 for the idx and tail_cnt widths.
- One sub-module, conv_codeword (parameters K, N, G): purely combinational, maps s_new to c[N-1:0]. It is reused by the future punctured encoder.

## Test plan
- Reset, then the default parameters, then in_data 1,0,1,1 with in_last on the final bit and out_ready always 1:
  - out_data is 1,1, 1,1, 1,0, 0,0, 1,0, 0,1.
  - out_last is high only on the 12th bit, then the FSM returns to IDLE with s=0.
- Same stimulus with out_ready toggling 1/0 pseudo-randomly: the identical 12-bit sequence appears. out_data is stable through every stall, and in_ready never rises during TAIL.
- Back-to-back: 8 bits with in_valid held 1 and out_ready held 1 give exactly 16 consecutive out_valid cycles with no bubble. in_ready is high only on every 2nd cycle.
- Reset pulse asserted after the 3rd coded bit of a block: out_valid drops asynchronously. A fresh single-bit block 1 (last) then gives 1,1,1,1,0,1 with out_last on the 6th bit, which confirms s was cleared.
- K=7, N=2, G=NASA, a single 1 with in_last: the 14 coded bits equal the polynomial tap pattern of G_0 and G_1 interleaved; out_last is on bit 14.
- Parameter sweep over N=3 and K=4 with random G, checked against a reference-model scoreboard over 10k random bits and random block lengths: zero mismatches.
